// File: rtl/audio_pkg.sv
// Shared types and defaults for the audio DAC scheduler.
package audio_pkg;

  localparam int DW_DEFAULT       = 16;
  localparam int SLOT_MAX_DEFAULT = 64;

  // Serializer sequencing states
  typedef enum logic [1:0] {
    WAIT_SYNC = 2'd0,
    LEFT      = 2'd1,
    RIGHT     = 2'd2
  } dac_state_t;

  // One stereo sample pair at the default width; left occupies the upper half
  typedef struct packed {
    logic [DW_DEFAULT-1:0] left;
    logic [DW_DEFAULT-1:0] right;
  } stereo_t;

  // Increment that sticks at all-ones
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/audio_dac_sched_rr_arb2.sv
// Two-way round-robin arbiter. The pointer remembers the last requester
// that actually completed a transfer, so an offered-but-unused grant does
// not cost a requester its turn.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] valid,
  input  logic       accept,
  output logic [1:0] grant
);

  logic last;

  // Grant the lone requester, or on a tie the one not served last
  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // Pointer moves only when a grant is turned into a transfer
  always_ff @(posedge clk) begin
    if (reset) begin
      last <= 1'b1;
    end else if (accept) begin
      last <= grant[1];
    end
  end

endmodule

// File: rtl/audio_dac_sched.sv
// I2S-style DAC scheduler: tracks the codec LR clock, arbitrates one stereo
// pair per frame between two requesters and serializes it MSB first.
//
// state     | meaning
// WAIT_SYNC | no valid frame alignment; output muted until an LRCK rise
// LEFT      | shifting the left word (LRCK high)
// RIGHT     | shifting the right word (LRCK low)
module audio_dac_sched
  import audio_pkg::*;
#(
  parameter int DW       = DW_DEFAULT,
  parameter int SLOT_MAX = SLOT_MAX_DEFAULT
) (
  input  logic          AUD_BCLK,
  input  logic          reset,
  input  logic          AUD_DACLRCK,
  input  logic [1:0]    req_valid,
  input  logic [2*DW-1:0] req0_data,
  input  logic [2*DW-1:0] req1_data,
  output logic [1:0]    req_ready,
  output logic          AUD_DACDAT,
  output logic          frame_start,
  output logic          active_src,
  output logic [7:0]    underrun_cnt,
  output logic          sync_lost
);

  localparam int CW = (SLOT_MAX > 1) ? $clog2(SLOT_MAX) : 1;

  dac_state_t      state, state_nxt;
  logic            lrck_q;
  logic            rise, fall;
  logic            take_rise, take_fall, timeout;
  logic [CW-1:0]   bit_cnt;
  logic            slot_end;
  logic [1:0]      arb_grant;
  logic            transfer;
  logic [2*DW-1:0] sel_pair;
  logic [DW-1:0]   shift;
  logic [DW-1:0]   hold_right;

  assign rise     = AUD_DACLRCK & ~lrck_q;
  assign fall     = ~AUD_DACLRCK & lrck_q;
  assign slot_end = (bit_cnt == CW'(SLOT_MAX - 1));
  assign transfer = |(req_valid & req_ready);
  assign sel_pair = arb_grant[1] ? req1_data : req0_data;

  rr_arb2 u_arb (
    .clk    (AUD_BCLK),
    .reset  (reset),
    .valid  (req_valid),
    .accept (transfer),
    .grant  (arb_grant)
  );

  // Next state, edge acceptance and the same-cycle grant window
  always_comb begin
    state_nxt   = state;
    take_rise   = 1'b0;
    take_fall   = 1'b0;
    timeout     = 1'b0;
    req_ready   = 2'b00;
    frame_start = 1'b0;
    case (state)
      WAIT_SYNC: begin
        if (rise) begin
          state_nxt = LEFT;
          take_rise = 1'b1;
        end
      end
      LEFT: begin
        if (fall) begin
          state_nxt = RIGHT;
          take_fall = 1'b1;
        end else if (slot_end) begin
          state_nxt = WAIT_SYNC;
          timeout   = 1'b1;
        end
      end
      RIGHT: begin
        if (rise) begin
          state_nxt = LEFT;
          take_rise = 1'b1;
        end else if (slot_end) begin
          state_nxt = WAIT_SYNC;
          timeout   = 1'b1;
        end
      end
      default: state_nxt = WAIT_SYNC;
    endcase
    // A reset cycle must never hand out a grant
    if (take_rise && !reset) begin
      frame_start = 1'b1;
      req_ready   = arb_grant;
    end
  end

  // LRCK history, state register and per-slot bit counter
  always_ff @(posedge AUD_BCLK) begin
    if (reset) begin
      lrck_q  <= 1'b0;
      state   <= WAIT_SYNC;
      bit_cnt <= '0;
    end else begin
      lrck_q <= AUD_DACLRCK;
      state  <= state_nxt;
      if (take_rise || take_fall || state_nxt == WAIT_SYNC) begin
        bit_cnt <= '0;
      end else begin
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

  // Serializer: left word enters straight from the granted pair, right word
  // from the hold register; zeros fill the slot once DW bits are out
  always_ff @(posedge AUD_BCLK) begin
    if (reset) begin
      shift      <= '0;
      hold_right <= '0;
      AUD_DACDAT <= 1'b0;
    end else begin
      if (state == WAIT_SYNC || timeout) begin
        AUD_DACDAT <= 1'b0;
      end else begin
        AUD_DACDAT <= shift[DW-1];
      end
      if (take_rise) begin
        shift      <= transfer ? sel_pair[2*DW-1:DW] : '0;
        hold_right <= transfer ? sel_pair[DW-1:0] : '0;
      end else if (take_fall) begin
        shift <= hold_right;
      end else if (state == WAIT_SYNC || timeout) begin
        shift <= '0;
      end else begin
        shift <= {shift[DW-2:0], 1'b0};
      end
    end
  end

  // Status: playing source, underrun tally and sticky loss of sync
  always_ff @(posedge AUD_BCLK) begin
    if (reset) begin
      active_src   <= 1'b0;
      underrun_cnt <= 8'd0;
      sync_lost    <= 1'b0;
    end else begin
      if (transfer) begin
        active_src <= arb_grant[1];
      end
      if (take_rise && !transfer) begin
        underrun_cnt <= sat_inc8(underrun_cnt);
      end
      if (timeout) begin
        sync_lost <= 1'b1;
      end
    end
  end

endmodule
